// File: rtl/dff_skid.sv
// dff_skid: two-entry valid/ready register stage (skid buffer).
// The main register drives out_q; the skid register catches the word that
// arrives in the same cycle the consumer stalls. Every handshake output
// (in_rdy, out_vld, occ) comes straight from a flop, so the ready path is
// cut between the neighbouring pipeline stages.
module dff_skid #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         in_vld,
    input  logic [W-1:0] in_d,
    output logic         in_rdy,
    output logic         out_vld,
    output logic [W-1:0] out_q,
    input  logic         out_rdy,
    output logic [1:0]   occ
);

    localparam logic [1:0] EMPTY = 2'd0;
    localparam logic [1:0] ONE   = 2'd1;
    localparam logic [1:0] FULL  = 2'd2;

    logic [W-1:0] skid;
    logic [1:0]   occ_next;
    logic         in_rdy_next;
    logic         out_vld_next;
    logic         load_in;
    logic         load_skid;
    logic         capture_skid;
    logic         push;
    logic         pop;

    assign push = in_vld & in_rdy;
    assign pop  = out_vld & out_rdy;

    // State register: occupancy plus the flopped handshake outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            occ     <= EMPTY;
            in_rdy  <= 1'b1;
            out_vld <= 1'b0;
        end else begin
            occ     <= occ_next;
            in_rdy  <= in_rdy_next;
            out_vld <= out_vld_next;
        end
    end

    // Next-state logic: occupancy after this edge's push/pop; flush empties.
    always_comb begin
        occ_next = occ;
        case (occ)
            EMPTY: if (push) occ_next = ONE;
            ONE: begin
                if (push && !pop)      occ_next = FULL;
                else if (!push && pop) occ_next = EMPTY;
            end
            FULL: if (pop) occ_next = ONE;
            default: occ_next = EMPTY;
        endcase
        if (flush) occ_next = EMPTY;
    end

    // Output logic: next handshake flags and the data-register load enables.
    // Flush suppresses every data load so a discarded word never reaches out_q.
    always_comb begin
        in_rdy_next  = (occ_next != FULL);
        out_vld_next = (occ_next != EMPTY);
        load_in      = !flush && push && ((occ == EMPTY) || ((occ == ONE) && pop));
        load_skid    = !flush && pop && (occ == FULL);
        capture_skid = !flush && push && !pop && (occ == ONE);
    end

    // Data registers: main follows the head of the buffer, skid holds the
    // second word; skid is deliberately left alone when it drains.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_q <= '0;
            skid  <= '0;
        end else begin
            if (load_in)
                out_q <= in_d;
            else if (load_skid)
                out_q <= skid;
            if (capture_skid)
                skid <= in_d;
        end
    end

    // Occupancy 3 is unreachable.
    a_occ_range: assert property (@(posedge clk) disable iff (!rst_n) occ <= FULL);

    // A push can only happen while the stage reports ready.
    a_push_rdy: assert property (@(posedge clk) disable iff (!rst_n) push |-> in_rdy);

    // A stalled output word stays put until the consumer takes it.
    a_stall_stable: assert property (@(posedge clk) disable iff (!rst_n)
        (out_vld && !out_rdy && !flush) |=> (out_vld && $stable(out_q)));

endmodule

// File: tb/tb_dff_skid.sv
// Testbench for dff_skid (W=8): directed scenarios plus random backpressure,
// checked against a queue-based reference of the buffer contents.
module tb_dff_skid;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       flush;
    logic       in_vld;
    logic [7:0] in_d;
    logic       in_rdy;
    logic       out_vld;
    logic [7:0] out_q;
    logic       out_rdy;
    logic [1:0] occ;

    int tests = 0;
    int fails = 0;

    // Reference state: words held by the stage, oldest first, and the value
    // out_q is required to show (last head word, or zero after reset).
    logic [7:0] mq[$];
    logic [7:0] hold_q;
    bit         started = 1'b0;

    dff_skid #(.W(8)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_vld(in_vld), .in_d(in_d), .in_rdy(in_rdy),
        .out_vld(out_vld), .out_q(out_q), .out_rdy(out_rdy),
        .occ(occ)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_ne(input string name, input int act, input int forbidden);
        tests++;
        if (act === forbidden) begin
            fails++;
            $display("FAIL %s: got %0h which must not appear at %0t", name, act, $time);
        end
    endtask

    // Apply inputs, then let one clock edge consume them; returns 2ns after it.
    task automatic drive(input logic v, input logic [7:0] d, input logic r, input logic f);
        in_vld  = v;
        in_d    = d;
        out_rdy = r;
        flush   = f;
        @(posedge clk);
        #2;
    endtask

    // Reference update at every edge: acceptance decided from the queue depth.
    always @(posedge clk) begin
        bit push, pop;
        if (!rst_n) begin
            mq.delete();
            hold_q  = 8'h00;
            started = 1'b1;
        end else if (started) begin
            push = in_vld && (mq.size() < 2);
            pop  = (mq.size() > 0) && out_rdy;
            if (pop) void'(mq.pop_front());
            if (flush) mq.delete();
            else if (push) mq.push_back(in_d);
            if (mq.size() > 0) hold_q = mq[0];
        end
    end

    // Monitor: compare the DUT's presented state against the reference.
    always @(negedge clk) begin
        if (started) begin
            check("in_rdy",  int'(in_rdy),  int'(mq.size() < 2));
            check("out_vld", int'(out_vld), int'(mq.size() > 0));
            check("occ",     int'(occ),     mq.size());
            check("out_q",   int'(out_q),   int'(hold_q));
        end
    end

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_vld = 1'b0; in_d = 8'h00; out_rdy = 1'b0;
        @(posedge clk); #2;
        @(posedge clk); #2;
        check("reset_occ", int'(occ), 0);
        check("reset_in_rdy", int'(in_rdy), 1);
        check("reset_out_q", int'(out_q), 0);
        rst_n = 1'b1;

        // Streaming at full throughput.
        for (int i = 1; i <= 16; i++) begin
            drive(1'b1, 8'(i), 1'b1, 1'b0);
            check("stream_q", int'(out_q), i);
            check("stream_occ", int'(occ), 1);
            check("stream_rdy", int'(in_rdy), 1);
        end
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        check("stream_drain_occ", int'(occ), 0);

        // Stall fill then drain in order.
        drive(1'b1, 8'hA1, 1'b0, 1'b0);
        drive(1'b1, 8'hA2, 1'b0, 1'b0);
        check("fill_occ", int'(occ), 2);
        check("fill_rdy", int'(in_rdy), 0);
        check("fill_q", int'(out_q), 8'hA1);
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        check("drain1_q", int'(out_q), 8'hA2);
        check("drain1_rdy", int'(in_rdy), 1);
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        check("drain2_occ", int'(occ), 0);

        // Flush while full, with a coinciding push that must be dropped.
        drive(1'b1, 8'h55, 1'b0, 1'b0);
        drive(1'b1, 8'h66, 1'b0, 1'b0);
        drive(1'b1, 8'h77, 1'b0, 1'b1);
        check("flush_occ", int'(occ), 0);
        check("flush_vld", int'(out_vld), 0);
        check("flush_rdy", int'(in_rdy), 1);
        check_ne("flush_q", int'(out_q), 8'h77);
        drive(1'b1, 8'h88, 1'b0, 1'b0);
        check("after_flush_q", int'(out_q), 8'h88);
        check("after_flush_vld", int'(out_vld), 1);
        drive(1'b0, 8'h00, 1'b1, 1'b0);

        // Reset while full.
        drive(1'b1, 8'h11, 1'b0, 1'b0);
        drive(1'b1, 8'h22, 1'b0, 1'b0);
        check("prereset_occ", int'(occ), 2);
        rst_n = 1'b0;
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        rst_n = 1'b1;
        check("midreset_occ", int'(occ), 0);
        check("midreset_vld", int'(out_vld), 0);
        check("midreset_q", int'(out_q), 0);
        check("midreset_rdy", int'(in_rdy), 1);
        drive(1'b1, 8'h3C, 1'b0, 1'b0);
        check("postreset_q", int'(out_q), 8'h3C);
        drive(1'b0, 8'h00, 1'b1, 1'b0);

        // Simultaneous push and pop at ONE.
        drive(1'b1, 8'h10, 1'b0, 1'b0);
        drive(1'b1, 8'h20, 1'b1, 1'b0);
        check("pushpop_q", int'(out_q), 8'h20);
        check("pushpop_occ", int'(occ), 1);
        drive(1'b0, 8'h00, 1'b1, 1'b0);

        // Random traffic with backpressure and occasional flush.
        for (int i = 0; i < 10000; i++) begin
            drive(1'($urandom_range(0, 1)), 8'($urandom),
                  1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 63) == 0));
        end
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        check("final_occ", int'(occ), 0);

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/dff_skid.md
Name: dff_skid

Overview:
- Two-entry valid/ready register stage (skid buffer) for any W-bit datapath.
- Adds downstream backpressure to the plain `dff` register. A producer pushes on the input side; a consumer drains on the output side.
- Full throughput of 1 word/cycle and 1-cycle latency, with all handshake outputs driven directly from flops.
- Used to break ready-path timing between pipeline stages.

Parameters:
- W, 32, data width in bits (W >= 1).

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst_n  input  1  synchronous reset, active-low.
- flush  input  1  discard all buffered words.
- in_vld  input  1  producer offers in_d this cycle.
- in_d  input  W  producer data.
- in_rdy  output  1  stage can accept a word this cycle (registered).
- out_vld  output  1  out_q holds a valid word (registered).
- out_q  output  W  head-of-buffer data (registered).
- out_rdy  input  1  consumer accepts out_q this cycle.
- occ  output  2  current occupancy, 0..2 (registered).

Behaviour:
- Interface: one clock, clk. Reset rst_n is synchronous and active-low.
- Event definitions:
  - push = in_vld & in_rdy.
  - pop = out_vld & out_rdy.
  - Any transfer occurs only on a clk edge where the handshake holds.
- Storage:
  - main register drives out_q.
  - skid register holds a second word when the consumer stalls.
- States, encoded by occ:
  - EMPTY (0): out_vld=0, in_rdy=1.
  - ONE (1): out_vld=1, in_rdy=1.
  - FULL (2): out_vld=1, in_rdy=0.
- Transitions (flush=0):
  - EMPTY & push -> ONE; main<=in_d.
  - EMPTY & !push -> EMPTY.
  - ONE & push & pop -> ONE; main<=in_d.
  - ONE & push & !pop -> FULL; skid<=in_d; main unchanged.
  - ONE & !push & pop -> EMPTY.
  - ONE & neither -> ONE.
  - FULL & pop -> ONE; main<=skid. No push is possible because in_rdy=0.
  - FULL & !pop -> FULL.
- Latency: a word pushed at edge N is visible on out_q/out_vld after edge N. It is poppable in cycle N+1 at the earliest.
- Throughput: with out_rdy held at 1, one push and one pop every cycle; occ stays at 1.
- Ordering: strict FIFO. A word in skid always leaves after the word in main.
- Stability: while out_vld=1 and out_rdy=0, out_q holds constant.
- Register hold:
  - When out_vld=0, out_q holds its last value. Consumers must ignore it.
  - skid is not cleared on pop.
- in_rdy and out_vld are pure flop outputs. There is no combinational path from out_rdy to in_rdy, nor from in_vld to out_vld.
- flush=1 at an edge:
  - Next state is EMPTY (occ=0, out_vld=0, in_rdy=1), regardless of push or pop.
  - A push coinciding with flush is discarded.
  - A pop coinciding with flush completes normally from the consumer's view.
- Reset: rst_n=0 at an edge forces occ=0, out_vld=0, in_rdy=1, out_q=0, skid=0.
  - Reset has priority over flush and all handshakes.
  - Reset mid-operation discards buffered words.
  - The first cycle after rst_n rises accepts a push.
- occ never exceeds 2. occ=3 is unreachable; simulation asserts occ<=2.
- Simulation asserts:
  - no push while in_rdy=0 (this holds by construction of push);
  - out_q/out_vld stable under stall.

Test Plan:
- Streaming: W=8, out_rdy=1, push 0x01..0x10 on consecutive cycles -> out_q shows 0x01..0x10 one cycle later, with no gaps; occ=1 throughout; in_rdy stays 1.
- Stall fill:
  - Push 0xA1, then 0xA2 with out_rdy=0 -> occ=2, in_rdy=0, out_q=0xA1 held.
  - Raise out_rdy -> pops 0xA1 then 0xA2 in order; occ returns to 0; in_rdy=1 one edge after the first pop.
- Random backpressure: random in_vld/out_rdy for 10k cycles -> output sequence equals input sequence; no loss or duplication; out_q stable during every stall.
- Flush:
  - FULL with 0x55/0x66 buffered, assert flush with in_vld=1, in_d=0x77 -> next cycle occ=0, out_vld=0, in_rdy=1; 0x77 never appears.
  - Subsequent push of 0x88 emerges first.
- Reset mid-operation: occ=2, drive rst_n=0 for one edge -> occ=0, out_vld=0, out_q=0x00, in_rdy=1. Push 0x3C right after release -> out_q=0x3C next cycle.
- Simultaneous push/pop at ONE: main=0x10, push 0x20 with out_rdy=1 -> out_q=0x20, occ stays 1, skid unused.
